// File: rtl/simon_3264_host_driver.sv
// Host-side master for the SIMON 32/64 core: input FIFO, key-load FSM and data FSM.
// Define SIMON_DRV_TIMEOUT_EN to enable the watchdog that drives the sticky err flag.
module simon_3264_host_driver #(
    parameter int unsigned N       = 16,
    parameter int unsigned M       = 4,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             R,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*N-1:0]   in_block,
    input  logic             in_enc_dec,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [M*N-1:0]   key_in,
    output logic             newData,
    output logic             newKey,
    output logic             enc_dec,
    output logic             readData,
    output logic [2*N-1:0]   plain,
    output logic [M*N-1:0]   key,
    input  logic             ldData,
    input  logic             ldKey,
    input  logic             doneData,
    input  logic [2*N-1:0]   cipher,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   out_block,
    output logic             out_enc_dec,
    output logic             key_loaded,
    output logic             err
);
    localparam int unsigned BW = 2 * N;
    localparam int unsigned KW = M * N;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT == 0) begin : g_bad_param
        $error("simon_3264_host_driver: DEPTH must be a power of 2 >= 2 and TIMEOUT nonzero");
    end

    typedef enum logic [2:0] {D_IDLE, D_LOAD, D_RUN, D_READ, D_OUT} d_state_t;
    typedef enum logic {K_IDLE, K_LOAD} k_state_t;

    d_state_t d_state, d_nxt;
    k_state_t k_state, k_nxt;

    logic [BW:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [BW:0]   head;
    logic          push, pop, tmo;

    logic [BW-1:0] plain_nxt, out_block_nxt;
    logic [KW-1:0] key_nxt;
    logic          enc_dec_nxt, new_data_nxt, new_key_nxt, key_loaded_nxt;
    logic          read_data_nxt, out_valid_nxt, out_enc_dec_nxt;

    assign in_ready  = (count != CW'(DEPTH));
    assign key_ready = (k_state == K_IDLE) && (d_state == D_IDLE);
    assign push      = in_valid && in_ready;
    assign head      = mem[rd_ptr];

    // FIFO storage; entry = {direction, block}
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_enc_dec, in_block};
    end

    always_ff @(posedge clk) begin
        if (R) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Next-state and next-output logic for both FSMs; key wins ties with data
    always_comb begin
        d_nxt           = d_state;
        k_nxt           = k_state;
        plain_nxt       = plain;
        enc_dec_nxt     = enc_dec;
        new_data_nxt    = newData;
        key_nxt         = key;
        new_key_nxt     = newKey;
        key_loaded_nxt  = key_loaded;
        read_data_nxt   = readData;
        out_valid_nxt   = out_valid;
        out_block_nxt   = out_block;
        out_enc_dec_nxt = out_enc_dec;
        pop             = 1'b0;

        case (k_state)
            K_IDLE: if (key_valid && key_ready) begin
                key_nxt     = key_in;
                new_key_nxt = 1'b1;
                k_nxt       = K_LOAD;
            end
            K_LOAD: if (ldKey) begin
                new_key_nxt    = 1'b0;
                key_loaded_nxt = 1'b1;
                k_nxt          = K_IDLE;
            end
        endcase

        case (d_state)
            D_IDLE: if (count != '0 && key_loaded && k_state == K_IDLE
                        && !(key_valid && key_ready)) begin
                plain_nxt    = head[BW-1:0];
                enc_dec_nxt  = head[BW];
                new_data_nxt = 1'b1;
                pop          = 1'b1;
                d_nxt        = D_LOAD;
            end
            D_LOAD: if (ldData) begin
                new_data_nxt = 1'b0;
                d_nxt        = D_RUN;
            end
            D_RUN: if (doneData) begin
                out_block_nxt   = cipher;
                out_enc_dec_nxt = enc_dec;
                read_data_nxt   = 1'b1;
                d_nxt           = D_READ;
            end
            D_READ: if (!doneData) begin
                read_data_nxt = 1'b0;
                out_valid_nxt = 1'b1;
                d_nxt         = D_OUT;
            end
            D_OUT: if (out_ready) begin
                out_valid_nxt = 1'b0;
                d_nxt         = D_IDLE;
            end
            default: d_nxt = D_IDLE;
        endcase

        if (tmo) begin
            new_data_nxt  = 1'b0;
            new_key_nxt   = 1'b0;
            read_data_nxt = 1'b0;
            d_nxt         = D_IDLE;
            k_nxt         = K_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (R) begin
            d_state     <= D_IDLE;
            k_state     <= K_IDLE;
            plain       <= '0;
            enc_dec     <= 1'b0;
            newData     <= 1'b0;
            key         <= '0;
            newKey      <= 1'b0;
            key_loaded  <= 1'b0;
            readData    <= 1'b0;
            out_valid   <= 1'b0;
            out_block   <= '0;
            out_enc_dec <= 1'b0;
        end else begin
            d_state     <= d_nxt;
            k_state     <= k_nxt;
            plain       <= plain_nxt;
            enc_dec     <= enc_dec_nxt;
            newData     <= new_data_nxt;
            key         <= key_nxt;
            newKey      <= new_key_nxt;
            key_loaded  <= key_loaded_nxt;
            readData    <= read_data_nxt;
            out_valid   <= out_valid_nxt;
            out_block   <= out_block_nxt;
            out_enc_dec <= out_enc_dec_nxt;
        end
    end

`ifdef SIMON_DRV_TIMEOUT_EN
    localparam int unsigned TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [TW-1:0] tmo_cnt;
    logic          busy;

    // Cycles spent in the current handshake state; cleared on any state change
    assign busy = (k_state == K_LOAD) || (d_state == D_LOAD) ||
                  (d_state == D_RUN)  || (d_state == D_READ);
    assign tmo  = busy && (tmo_cnt == TW'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (R) begin
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (!busy || d_nxt != d_state || k_nxt != k_state) tmo_cnt <= '0;
            else                                                tmo_cnt <= tmo_cnt + TW'(1);
            if (tmo) err <= 1'b1;
        end
    end
`else
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_simon_3264_host_driver.sv
// Self-checking bench for simon_3264_host_driver with a behavioural SIMON core responder.
// Define SIMON_DRV_TIMEOUT_EN to also exercise the watchdog.
module tb_simon_3264_host_driver;
    localparam int unsigned N       = 16;
    localparam int unsigned M       = 4;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 255;
    localparam logic [63:0] KEY = 64'h1918111009080100;
    localparam logic [31:0] PT  = 32'h65656877;
    localparam logic [31:0] CT  = 32'hC69BE9BB;

    logic        clk, R;
    logic        in_valid, in_ready, in_enc_dec;
    logic [31:0] in_block;
    logic        key_valid, key_ready;
    logic [63:0] key_in;
    logic        newData, newKey, enc_dec, readData;
    logic [31:0] plain;
    logic [63:0] key;
    logic        ldData, ldKey, doneData;
    logic [31:0] cipher;
    logic        out_valid, out_ready, out_enc_dec;
    logic [31:0] out_block;
    logic        key_loaded, err;

    simon_3264_host_driver #(.N(N), .M(M), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .R(R),
        .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block), .in_enc_dec(in_enc_dec),
        .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
        .newData(newData), .newKey(newKey), .enc_dec(enc_dec), .readData(readData),
        .plain(plain), .key(key),
        .ldData(ldData), .ldKey(ldKey), .doneData(doneData), .cipher(cipher),
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
        .out_enc_dec(out_enc_dec), .key_loaded(key_loaded), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [32:0] sb[$];
    logic        ld_data_en;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Core transfer function: real SIMON vectors for the reference key, a fixed mix otherwise
    function automatic logic [31:0] core_f(input logic [31:0] b, input logic d, input logic [63:0] k);
        if (k == KEY && d && b == PT)  return CT;
        if (k == KEY && !d && b == CT) return PT;
        return {b[15:0], b[31:16]} ^ k[31:0] ^ (d ? 32'h9E3779B9 : 32'h7F4A7C15);
    endfunction

    // Core responder: latches key/data on its ld pulse, holds doneData until readData seen
    logic [1:0]  cst;
    int          kcnt, dcnt;
    logic [31:0] c_plain;
    logic        c_dir;
    logic [63:0] c_key;
    always @(posedge clk) begin
        if (R) begin
            ldKey <= 1'b0; ldData <= 1'b0; doneData <= 1'b0; cipher <= '0;
            cst <= 2'd0; kcnt <= 0; dcnt <= 0; c_key <= '0; c_plain <= '0; c_dir <= 1'b0;
        end else begin
            ldKey <= 1'b0;
            if (newKey && !ldKey) begin
                if (kcnt >= 2) begin ldKey <= 1'b1; c_key <= key; kcnt <= 0; end
                else kcnt <= kcnt + 1;
            end else kcnt <= 0;
            case (cst)
                2'd0: begin
                    ldData <= 1'b0;
                    if (newData && ld_data_en) begin
                        if (dcnt >= 1) begin
                            ldData <= 1'b1; c_plain <= plain; c_dir <= enc_dec;
                            cst <= 2'd1; dcnt <= 0;
                        end else dcnt <= dcnt + 1;
                    end else dcnt <= 0;
                end
                2'd1: begin
                    ldData <= 1'b0;
                    if (dcnt >= 3) begin
                        doneData <= 1'b1; cipher <= core_f(c_plain, c_dir, c_key);
                        cst <= 2'd2; dcnt <= 0;
                    end else dcnt <= dcnt + 1;
                end
                default: if (readData) begin doneData <= 1'b0; cst <= 2'd0; end
            endcase
        end
    end

    // Output monitor: pops the scoreboard on each accepted result
    always @(negedge clk) begin
        if (!R && out_valid && out_ready) begin
            if (sb.size() == 0) check("out_unexpected", 64'(sb.size()), 64'd1);
            else check("out_result", 64'({out_enc_dec, out_block}), 64'(sb.pop_front()));
        end
    end

    task automatic sync();
        @(posedge clk); #1;
    endtask

    task automatic push_block(input logic [31:0] b, input logic d, input logic [31:0] exp, input bit track);
        int w = 0;
        in_block = b; in_enc_dec = d; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && w < 500) begin @(negedge clk); w++; end
        check("push_accept", 64'(in_ready), 64'd1);
        if (in_ready && track) sb.push_back({d, exp});
        sync();
        in_valid = 1'b0;
    endtask

    task automatic load_key(input logic [63:0] k);
        int w = 0;
        key_in = k; key_valid = 1'b1;
        @(negedge clk);
        while (!key_ready && w < 500) begin @(negedge clk); w++; end
        check("key_accept", 64'(key_ready), 64'd1);
        sync();
        key_valid = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int w = 0;
        while (sb.size() != 0 && w < limit) begin @(negedge clk); w++; end
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w;
        logic [31:0] b;
        R = 1'b1; in_valid = 1'b0; in_block = '0; in_enc_dec = 1'b0;
        key_valid = 1'b0; key_in = '0; out_ready = 1'b1; ld_data_en = 1'b1;

        // Reset
        @(negedge clk);
        check("rst_ctrl", 64'({newData, newKey, readData, out_valid, key_loaded, err, enc_dec, out_enc_dec}), 64'd0);
        check("rst_data", 64'({plain, out_block}), 64'd0);
        check("rst_key", key, 64'd0);
        @(posedge clk); #1 R = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_key_ready", 64'(key_ready), 64'd1);
        sync();

        // Block queued before any key must wait
        push_block(PT, 1'b1, CT, 1'b1);
        repeat (10) @(negedge clk);
        check("no_data_before_key", 64'({newData, key_loaded}), 64'd0);
        sync();

        // Key load
        load_key(KEY);
        @(negedge clk);
        check("newkey_high", 64'(newKey), 64'd1);
        check("key_value", key, KEY);
        w = 0;
        while (!key_loaded && w < 100) begin @(negedge clk); w++; end
        check("key_loaded", 64'({key_loaded, newKey}), 64'b10);
        check("key_hold", key, KEY);

        // Encrypt of the queued block
        w = 0;
        while (!newData && w < 100) begin @(negedge clk); w++; end
        check("enc_newdata", 64'(newData), 64'd1);
        check("enc_plain", 64'({enc_dec, plain}), 64'({1'b1, PT}));
        check("key_blocked", 64'(key_ready), 64'd0);
        wait_drain(200);
        sync();

        // Decrypt round trip
        push_block(CT, 1'b0, PT, 1'b1);
        wait_drain(200);
        sync();

        // Backpressure: DEPTH+1 blocks with the sink stalled
        out_ready = 1'b0;
        for (int i = 0; i < int'(DEPTH) + 1; i++) begin
            b = $urandom;
            push_block(b, i[0], core_f(b, i[0], KEY), 1'b1);
        end
        repeat (20) @(negedge clk);
        check("bp_full", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_hold", 64'({out_enc_dec, out_block}), 64'(sb[0]));
        sync();
        out_ready = 1'b1;
        wait_drain(500);
        @(negedge clk);
        check("bp_ready_again", 64'(in_ready), 64'd1);
        sync();

`ifdef SIMON_DRV_TIMEOUT_EN
        // Watchdog: core never acknowledges the data load
        ld_data_en = 1'b0;
        push_block(PT, 1'b1, CT, 1'b0);
        w = 0;
        while (!err && w < int'(TIMEOUT) + 100) begin @(negedge clk); w++; end
        check("tmo_err", 64'(err), 64'd1);
        @(negedge clk);
        check("tmo_idle", 64'({newData, readData, key_ready}), 64'b001);
        sync();
        R = 1'b1;
        sync();
        R = 1'b0;
        ld_data_en = 1'b1;
        @(negedge clk);
        check("tmo_err_clear", 64'(err), 64'd0);
`else
        check("err_tied", 64'(err), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/simon_3264_host_driver.md
Name: simon_3264_host_driver

Overview:
- Host-side master for the SIMON 32/64 core handshake (newData/ldData, newKey/ldKey, doneData/readData).
- Accepts plaintext/ciphertext blocks from a valid/ready stream into a small FIFO and loads round keys on request.
- Drives each block through the core and returns results on a valid/ready output stream.
- Sits between the system bus adapter and the SIMON_3264 instance.

Parameters:
N, 16, word width; block is 2*N bits.
M, 4, key words; key is M*N bits.
DEPTH, 4, input FIFO entries; power of 2, minimum 2.
TIMEOUT, 255, watchdog limit in cycles (used only with the optional feature).

Ports:
clk  input  1  system clock.
R  input  1  synchronous reset, active-high.
in_valid  input  1  input block offered.
in_ready  output  1  FIFO not full.
in_block  input  2N  block to process.
in_enc_dec  input  1  1 = encrypt, 0 = decrypt; stored per block.
key_valid  input  1  new key offered.
key_ready  output  1  key accepted this cycle when key_valid is high.
key_in  input  M*N  key, word M-1 in the MSBs.
newData  output  1  to core: request data load.
newKey  output  1  to core: request key load.
enc_dec  output  1  to core: direction.
readData  output  1  to core: result consumed.
plain  output  2N  to core: block.
key  output  M*N  to core: key.
ldData  input  1  from core: data latched.
ldKey  input  1  from core: key latched.
doneData  input  1  from core: cipher valid.
cipher  input  2N  from core: result.
out_valid  output  1  result available.
out_ready  input  1  downstream accepts.
out_block  output  2N  result.
out_enc_dec  output  1  direction used for the result.
key_loaded  output  1  at least one key has been loaded since reset.
err  output  1  sticky watchdog error.

Behaviour:
- Reset (R high at a clk edge) sets all outputs to 0, FIFO empty, both FSMs to IDLE, key_loaded 0, err 0. Reset mid-operation abandons the transfer and deasserts newData, newKey and readData on the next edge.
- FIFO: push on in_valid & in_ready. Pop when the data FSM leaves D_IDLE. in_ready = !full. Simultaneous push and pop when full is not allowed (in_ready low). Pointers wrap modulo DEPTH.
- Key FSM:
  - K_IDLE: key_ready = 1 only when the data FSM is in D_IDLE. On key_valid & key_ready, register key_in onto key and go to K_LOAD.
  - K_LOAD: newKey = 1. On ldKey = 1, deassert newKey next cycle, set key_loaded, return to K_IDLE.
- Data FSM:
  - D_IDLE: if FIFO not empty, key_loaded = 1 and the key FSM is in K_IDLE, register head block to plain and its direction to enc_dec, pop, go to D_LOAD.
  - D_LOAD: newData = 1 until ldData = 1 is sampled, then clear newData and go to D_RUN.
  - D_RUN: wait for doneData = 1. In that cycle, capture cipher into out_block and direction into out_enc_dec, assert readData, go to D_READ.
  - D_READ: hold readData until doneData = 0 is sampled, then clear readData and go to D_OUT.
  - D_OUT: out_valid = 1; on out_ready, clear out_valid and return to D_IDLE.
- Key/data exclusion: the key FSM and data FSM never both leave IDLE in the same cycle. Key has priority when both are eligible in the same cycle.
- Output timing: plain, key and enc_dec stay stable from the request edge until the matching ld* is sampled. out_block is held stable while out_valid = 1.
- Minimum latency, from FIFO head to out_valid: 1 cycle plus core load latency, plus core run time, plus 2 cycles.
- Level sensing: ld* and doneData are sampled as levels, never edges. A ld* already high on entry to a LOAD state completes that state in 1 cycle.

Optional Feature:
- Macro: SIMON_DRV_TIMEOUT_EN.
- Defined: an 8+ bit counter resets on each state change. If it reaches TIMEOUT while the driver is in K_LOAD, D_LOAD, D_RUN or D_READ, then:
  - err is set;
  - newData, newKey and readData are cleared;
  - both FSMs return to IDLE and the in-flight block is dropped.
  - err clears only on R.
- Not defined: no counter; err is tied to 0; the driver waits indefinitely.

Test Plan:
- Reset: R held for 2 cycles -> all outputs 0, in_ready = 1 after release, key_ready = 1.
- Key load: key_in 64'h1918111009080100 with key_valid -> newKey high until ldKey, then key_loaded = 1 and key holds that value.
- Encrypt: in_block 32'h65656877 with in_enc_dec = 1 -> plain = 32'h65656877 with newData until ldData; out_block = 32'hC69BE9BB with out_enc_dec = 1.
- Decrypt round-trip: push 32'hC69BE9BB with in_enc_dec = 0 -> out_block 32'h65656877. Block pushed before any key load -> no newData until key_loaded.
- Backpressure: push DEPTH+1 blocks with out_ready = 0 -> in_ready drops once the FIFO is full; results appear in order once out_ready = 1.
- Timeout (with macro): core model never raises ldData -> err = 1 after TIMEOUT cycles, newData = 0, FSM idle; R clears err.
